// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package hazard_pkg;

  localparam int REG_W_DEF = 5;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/fwd_select.sv
// Execute-stage operand forwarding select for one source register.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] src,
  input  logic [REG_W-1:0] writeregM,
  input  logic             regwriteM,
  input  logic [REG_W-1:0] writeregW,
  input  logic             regwriteW,
  output fwd_sel_t         sel
);

  // Memory stage holds the younger result, so it wins over writeback.
  always_comb begin
    sel = FWD_RF;
    if ((src != '0) && (src == writeregM) && regwriteM) begin
      sel = FWD_MEM;
    end else if ((src != '0) && (src == writeregW) && regwriteW) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Forwarding, load-use/branch stall, data-memory freeze and stall/flush counters
// for the five-stage MIPS pipeline.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] rsD,
  input  logic [REG_W-1:0] rtD,
  input  logic [REG_W-1:0] rsE,
  input  logic [REG_W-1:0] rtE,
  input  logic [REG_W-1:0] writeregE,
  input  logic [REG_W-1:0] writeregM,
  input  logic [REG_W-1:0] writeregW,
  input  logic             regwriteE,
  input  logic             regwriteM,
  input  logic             regwriteW,
  input  logic             memtoregE,
  input  logic             memtoregM,
  input  logic             memwriteM,
  input  logic             branchD,
  input  logic             dmem_ready,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             forwardAD,
  output logic             forwardBD,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushE,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  fwd_sel_t   fwd_a;
  fwd_sel_t   fwd_b;
  logic       lwstall;
  logic       brstall;
  logic       mem_busy;
  hz_state_t  state_q;
  hz_state_t  state_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;

  fwd_select #(.REG_W(REG_W)) u_fwd_a (
    .src       (rsE),
    .writeregM (writeregM),
    .regwriteM (regwriteM),
    .writeregW (writeregW),
    .regwriteW (regwriteW),
    .sel       (fwd_a)
  );

  fwd_select #(.REG_W(REG_W)) u_fwd_b (
    .src       (rtE),
    .writeregM (writeregM),
    .regwriteM (regwriteM),
    .writeregW (writeregW),
    .regwriteW (regwriteW),
    .sel       (fwd_b)
  );

  assign forwardAE = fwd_a;
  assign forwardBE = fwd_b;
  assign forwardAD = (rsD != '0) && (rsD == writeregM) && regwriteM;
  assign forwardBD = (rtD != '0) && (rtD == writeregM) && regwriteM;

  assign lwstall = memtoregE && ((rtE == rsD) || (rtE == rtD));

  // Branch compares in decode, so an ALU result still in E or a load in M is not yet forwardable.
  assign brstall = branchD &&
    ((regwriteE && (writeregE != '0) && ((writeregE == rsD) || (writeregE == rtD))) ||
     (memtoregM && (writeregM != '0) && ((writeregM == rsD) || (writeregM == rtD))));

  assign mem_busy = (memtoregM || memwriteM) && !dmem_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (mem_busy) state_d = MEMWAIT;
      MEMWAIT: if (dmem_ready) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // A memory freeze holds every stage and suppresses the hazard bubble.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushE = 1'b0;
    if ((state_q == MEMWAIT) || mem_busy) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
    end else begin
      stallF = lwstall || brstall;
      stallD = lwstall || brstall;
      flushE = lwstall || brstall;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stallF && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flushE && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_cnt_q <= '0;
    end else begin
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
